// File: rtl/cmd_loader.sv
// Command memory loader: packs a valid/ready word stream into CMD_WIDTH commands
// and writes them to consecutive addresses starting at a programmed base.
module cmd_loader #(
  parameter int WORD_WIDTH     = 32,
  parameter int CMD_WIDTH      = 128,
  parameter int CMD_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CMD_ADDR_WIDTH-1:0] base_addr,
  input  logic [WORD_WIDTH-1:0]     word_in,
  input  logic                      word_valid,
  input  logic                      word_last,
  output logic                      word_ready,
  output logic [CMD_WIDTH-1:0]      cmd_write,
  output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
  output logic                      cmd_write_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [CMD_ADDR_WIDTH:0]   cmd_count,
  output logic [1:0]                state_dbg
);

  localparam int NWORDS = CMD_WIDTH / WORD_WIDTH;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  // Stream handshake: a word transfers on a rising edge where word_valid and
  // word_ready are both high; word_ready is high only in LOAD.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic [CMD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CMD_WIDTH-1:0]      asm_q, asm_d;
  logic                      last_q, last_d;
  logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
  logic [CMD_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [CMD_ADDR_WIDTH:0]   count_q, count_d;
  logic                      err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    waddr_d = waddr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = base_addr;
          idx_d   = '0;
          asm_d   = '0;
          last_d  = 1'b0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (word_valid) begin
          asm_d[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH] = word_in;
          if (idx_q == IDXW'(NWORDS-1) || word_last) begin
            // Capture the finished command now so the strobe cycle sees it registered.
            last_d  = word_last;
            cmd_d   = asm_d;
            waddr_d = addr_q;
            if (idx_q != IDXW'(NWORDS-1)) err_d = 1'b1;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + (CMD_ADDR_WIDTH+1)'(1);
        idx_d   = '0;
        asm_d   = '0;
        if (last_q) begin
          state_d = S_DONE;
        end else if (addr_q == '1) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + CMD_ADDR_WIDTH'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      asm_q   <= '0;
      last_q  <= 1'b0;
      cmd_q   <= '0;
      waddr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign word_ready       = (state_q == S_LOAD);
  assign cmd_write_enable = (state_q == S_WRITE);
  assign busy             = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done             = (state_q == S_DONE);
  assign error            = err_q;
  assign cmd_count        = count_q;
  assign cmd_write        = cmd_q;
  assign cmd_write_addr   = waddr_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_cmd_loader.sv
// Self-checking bench for cmd_loader: directed and randomized streams compared
// against a sequence-level model of command packing and addressing.
module tb_cmd_loader;

  localparam int NW = 4;

  logic         clk = 1'b0;
  logic         reset, start, word_valid, word_last;
  logic [15:0]  base_addr;
  logic [31:0]  word_in;
  logic         word_ready, cmd_write_enable, busy, done, error;
  logic [127:0] cmd_write;
  logic [15:0]  cmd_write_addr;
  logic [16:0]  cmd_count;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int ready_viol = 0;

  logic [31:0]  stim_w[$];
  logic [127:0] exp_q[$];
  logic [15:0]  exp_a[$];
  logic [127:0] obs_d[$];
  logic [15:0]  obs_a[$];
  logic         exp_err, exp_done;
  int           exp_acc, exp_cnt;

  cmd_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready), .cmd_write(cmd_write), .cmd_write_addr(cmd_write_addr),
    .cmd_write_enable(cmd_write_enable), .busy(busy), .done(done), .error(error),
    .cmd_count(cmd_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (cmd_write_enable) begin
      obs_d.push_back(cmd_write);
      obs_a.push_back(cmd_write_addr);
      if (word_ready) ready_viol++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: walk the word list in groups of NW, one write per group or early last.
  task automatic model(input logic [15:0] base, input int last_pos);
    logic [15:0]  addr;
    logic [127:0] cmd;
    int           slice;
    bit           lst;
    exp_q.delete(); exp_a.delete();
    addr = base; cmd = '0; slice = 0;
    exp_acc = 0; exp_err = 0; exp_done = 0;
    for (int i = 0; i < stim_w.size() && !exp_done; i++) begin
      exp_acc++;
      cmd = cmd | (128'(stim_w[i]) << (32 * slice));
      lst = (i + 1 == last_pos);
      if (lst || slice == NW - 1) begin
        exp_q.push_back(cmd);
        exp_a.push_back(addr);
        if (lst && slice != NW - 1) exp_err = 1;
        if (lst) exp_done = 1;
        else if (addr == 16'hFFFF) begin exp_err = 1; exp_done = 1; end
        else addr = addr + 16'd1;
        cmd = '0; slice = 0;
      end else begin
        slice++;
      end
    end
    exp_cnt = exp_q.size();
  endtask

  task automatic do_start(input logic [15:0] b);
    base_addr = b; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input bit last, output bit ok);
    int t = 0;
    word_in = w; word_last = last; word_valid = 1'b1; ok = 0;
    while (!word_ready && t < 12) begin cyc(1); t++; end
    if (word_ready) begin cyc(1); ok = 1; end
    word_valid = 1'b0; word_last = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, 128'(state_dbg), 128'd0);
    chk({tag, "_ready"}, 128'(word_ready), 128'd0);
    chk({tag, "_we"}, 128'(cmd_write_enable), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_err"}, 128'(error), 128'd0);
    chk({tag, "_cnt"}, 128'(cmd_count), 128'd0);
    chk({tag, "_data"}, cmd_write, 128'd0);
    chk({tag, "_addr"}, 128'(cmd_write_addr), 128'd0);
  endtask

  task automatic run_case(input string tag, input logic [15:0] base, input int last_pos,
                          input bit gaps, input bit poke_start);
    bit ok;
    int acc = 0;
    model(base, last_pos);
    obs_d.delete(); obs_a.delete();
    do_start(base);
    chk({tag, "_clr_err"}, 128'(error), 128'd0);
    chk({tag, "_clr_cnt"}, 128'(cmd_count), 128'd0);
    for (int i = 0; i < stim_w.size(); i++) begin
      if (gaps) cyc($urandom_range(0, 2));
      if (poke_start && i == 1) begin
        base_addr = 16'h3333; start = 1'b1; cyc(1); start = 1'b0; base_addr = base;
      end
      push_word(stim_w[i], (i + 1 == last_pos), ok);
      if (ok) acc++;
    end
    cyc(3);
    chk({tag, "_accepted"}, 128'(acc), 128'(exp_acc));
    chk({tag, "_nwrites"}, 128'(obs_d.size()), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_d.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 128'(obs_a[k]), 128'(exp_a[k]));
      chk($sformatf("%s_data%0d", tag, k), obs_d[k], exp_q[k]);
    end
    chk({tag, "_done"}, 128'(done), 128'(exp_done));
    chk({tag, "_err"}, 128'(error), 128'(exp_err));
    chk({tag, "_cnt"}, 128'(cmd_count), 128'(exp_cnt));
    chk({tag, "_rdy_in_write"}, 128'(ready_viol), 128'd0);
  endtask

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; base_addr = '0;
    word_in = '0; word_valid = 1'b0; word_last = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check_idle("reset");

    // Basic load: 1..8, last on word 8
    stim_w.delete();
    for (int i = 1; i <= 8; i++) stim_w.push_back(32'(i));
    run_case("basic", 16'h0010, 8, 0, 0);
    if (obs_d.size() > 0) chk("basic_lit0", obs_d[0], 128'h00000004_00000003_00000002_00000001);

    // Restart from DONE with stray start pulses during LOAD
    stim_w.delete();
    for (int i = 0; i < 4; i++) stim_w.push_back($urandom);
    run_case("restart", 16'h0100, 4, 0, 1);

    // Same basic stream with random valid gaps
    stim_w.delete();
    for (int i = 1; i <= 8; i++) stim_w.push_back(32'(i));
    run_case("gaps", 16'h0010, 8, 1, 0);

    // Short last: 0xA..0xF, last on word 6
    stim_w.delete();
    for (int i = 10; i <= 15; i++) stim_w.push_back(32'(i));
    run_case("short", 16'h0000, 6, 0, 0);
    if (obs_d.size() > 1) chk("short_lit1", obs_d[1], 128'h00000000_00000000_0000000F_0000000E);

    // Restart after an error clears error and count
    stim_w.delete();
    for (int i = 0; i < 4; i++) stim_w.push_back($urandom);
    run_case("clr", 16'h0200, 4, 1, 0);

    // Address overflow at the top of memory
    stim_w.delete();
    for (int i = 0; i < 8; i++) stim_w.push_back($urandom);
    run_case("ovf", 16'hFFFF, 0, 0, 0);
    cyc(2);
    chk("ovf_ready_after", 128'(word_ready), 128'd0);

    // Reset mid-operation discards the partial command
    obs_d.delete(); obs_a.delete();
    do_start(16'h0040);
    push_word(32'hDEAD0001, 0, ok);
    push_word(32'hDEAD0002, 0, ok);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check_idle("midrst");
    chk("midrst_nowrite", 128'(obs_d.size()), 128'd0);
    stim_w.delete();
    for (int i = 0; i < 4; i++) stim_w.push_back($urandom);
    run_case("postrst", 16'h0020, 4, 0, 0);

    // Randomized programs, some near the top of memory
    for (int r = 0; r < 6; r++) begin
      logic [15:0] b;
      int n;
      n = $urandom_range(1, 12);
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 16'hFFF0));
      stim_w.delete();
      for (int i = 0; i < n; i++) stim_w.push_back($urandom);
      run_case($sformatf("rnd%0d", r), b, n, 1, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_loader.md
Name: cmd_loader

Overview:
- Upstream feeder for the command memory write port of the distributed processor.
- Accepts a 32-bit word stream with valid/ready handshaking and assembles CMD_WIDTH/WORD_WIDTH words into one command.
- Writes each assembled command to consecutive memory addresses starting at a programmed base address.
- Drives cmd_write, cmd_write_addr and cmd_write_enable, and reports busy, done, error and a command count.

Parameters:
- WORD_WIDTH, 32, width of one input stream word and of one memory slice.
- CMD_WIDTH, 128, assembled command width; must be an integer multiple of WORD_WIDTH. NWORDS = CMD_WIDTH/WORD_WIDTH (default 4).
- CMD_ADDR_WIDTH, 16, command memory address width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- base_addr  input  CMD_ADDR_WIDTH  first write address; sampled on an accepted start.
- word_in  input  WORD_WIDTH  stream data.
- word_valid  input  1  stream data valid.
- word_last  input  1  marks the final word of the program; qualified by word_valid.
- word_ready  output  1  loader can accept a word.
- cmd_write  output  CMD_WIDTH  assembled command.
- cmd_write_addr  output  CMD_ADDR_WIDTH  write address.
- cmd_write_enable  output  1  single-cycle write strobe.
- busy  output  1  high in LOAD or WRITE.
- done  output  1  high while in DONE.
- error  output  1  sticky fault flag; cleared on an accepted start.
- cmd_count  output  CMD_ADDR_WIDTH+1  number of commands written since the last accepted start.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - state goes to IDLE; all outputs go to 0.
  - word index, address register and assembly register are cleared; any partial command is discarded.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - word_ready=0; incoming words are ignored.
  - On start: addr<=base_addr, idx<=0, assembly<=0, cmd_count<=0, error<=0, then go to LOAD.
- LOAD:
  - word_ready=1. A word is accepted when word_valid && word_ready.
  - Accepted word is written into slice idx, bits [WORD_WIDTH*(idx+1)-1 : WORD_WIDTH*idx]. The first word lands in the LSBs.
  - If idx<NWORDS-1 and word_last=0: idx increments and the loader stays in LOAD.
  - If idx==NWORDS-1, or word_last=1: latch last_flag<=word_last, go to WRITE.
  - If word_last=1 with idx<NWORDS-1: the unfilled upper slices remain 0, error<=1, and the command is still written.
  - start is ignored in LOAD.
- WRITE (exactly one cycle):
  - cmd_write_enable=1, cmd_write=assembly, cmd_write_addr=addr, word_ready=0.
  - cmd_write and cmd_write_addr are registered outputs; both hold their last values after the strobe.
  - cmd_count increments; idx<=0; assembly<=0.
  - If last_flag: go to DONE.
  - Else if addr==2^CMD_ADDR_WIDTH-1: error<=1 (address overflow), go to DONE. The address never wraps.
  - Else: addr<=addr+1, go to LOAD.
- DONE:
  - done=1, word_ready=0.
  - error and cmd_count hold their values.
  - start re-enters LOAD with the same initialisation as in IDLE.
- Latency: the write strobe is asserted on the cycle after the last word of a command is accepted.
- Peak throughput: NWORDS words per NWORDS+1 cycles.
- If start and reset are asserted together, reset wins.
- word_valid deasserted mid-command: stall with no timeout; idx and assembly are held.

Test Plan:
- Basic load: reset, then start with base_addr=0x0010; stream 8 words 0x1..0x8, last on word 8.
  - Write at 0x0010 = 0x00000004_00000003_00000002_00000001.
  - Write at 0x0011 = 0x00000008_00000007_00000006_00000005.
  - cmd_count=2, done=1, error=0, exactly 2 enable pulses.
- Backpressure/gaps: same stream with word_valid toggled randomly.
  - Identical writes are produced.
  - word_ready=0 during each WRITE cycle; no word is lost or duplicated.
- Short last: start base 0x0000; 6 words 0xA..0xF, last on word 6.
  - Second write at 0x0001 = 0x00000000_00000000_0000000F_0000000E.
  - error=1, cmd_count=2.
- Address overflow: start base 0xFFFF; stream 8 words with no last.
  - One write at 0xFFFF, then DONE with error=1, cmd_count=1.
  - word_ready stays 0 afterwards.
- Reset mid-operation: start, accept 2 words, assert reset for 1 cycle.
  - All outputs 0, state IDLE, no write.
  - A new start at base 0x0020 with 4 words writes correctly at 0x0020.
- Restart from DONE: after the basic load, start with base 0x0100 and 4 words.
  - error and cmd_count are cleared, then cmd_count=1; the write lands at 0x0100.
  - start pulses asserted during LOAD are ignored.
